// File: rtl/hash_table_pkg.sv
// Shared types and default widths for the hash-table read path.
// A bucket entry is stored in memory as {occupied, key, value}.
package hash_table_pkg;

  localparam int DEFAULT_KEY_WIDTH   = 10;
  localparam int DEFAULT_VALUE_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH  = 8;

  typedef struct packed {
    logic                           occupied;
    logic [DEFAULT_KEY_WIDTH-1:0]   key;
    logic [DEFAULT_VALUE_WIDTH-1:0] value;
  } bucket_entry_t;

  function automatic int entry_width(input int key_width, input int value_width);
    return 1 + key_width + value_width;
  endfunction

endpackage

// File: rtl/hash_lookup_if.sv
// Request, bucket-memory and result signals of the lookup stage.
// The slave modport is the lookup stage's view; master is the surrounding logic.
interface hash_lookup_if #(
  parameter int KEY_WIDTH   = hash_table_pkg::DEFAULT_KEY_WIDTH,
  parameter int VALUE_WIDTH = hash_table_pkg::DEFAULT_VALUE_WIDTH,
  parameter int ADDR_WIDTH  = hash_table_pkg::DEFAULT_ADDR_WIDTH
) ();

  logic                             req_valid;
  logic                             req_ready;
  logic [KEY_WIDTH-1:0]             req_key;
  logic [ADDR_WIDTH-1:0]            req_addr;
  logic                             mem_rd_en;
  logic [ADDR_WIDTH-1:0]            mem_rd_addr;
  logic [KEY_WIDTH+VALUE_WIDTH:0]   mem_rd_data;
  logic                             res_valid;
  logic                             res_ready;
  logic                             res_hit;
  logic [KEY_WIDTH-1:0]             res_key;
  logic [VALUE_WIDTH-1:0]           res_value;

  modport slave (
    input  req_valid, req_key, req_addr, mem_rd_data, res_ready,
    output req_ready, mem_rd_en, mem_rd_addr, res_valid, res_hit, res_key, res_value
  );

  modport master (
    output req_valid, req_key, req_addr, mem_rd_data, res_ready,
    input  req_ready, mem_rd_en, mem_rd_addr, res_valid, res_hit, res_key, res_value
  );

endinterface

// File: rtl/siso_register.sv
// Serial-in serial-out register chain: data_out is data_in delayed by DELAY
// enabled clock edges. Reset clears every stage so stale valids never emerge.
module siso_register #(
  parameter int DATA_WIDTH = 8,
  parameter int DELAY      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] stages [DELAY];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DELAY; i++) stages[i] <= '0;
    end else if (write_en) begin
      stages[0] <= data_in;
      for (int i = 1; i < DELAY; i++) stages[i] <= stages[i-1];
    end
  end

  assign data_out = stages[DELAY-1];

endmodule

// File: rtl/hash_lookup_stage.sv
// Hash-table lookup stage: issues bucket reads, compares the returned entry
// with the delayed key and queues hit/miss results in a credit-protected FIFO.
module hash_lookup_stage
  import hash_table_pkg::*;
#(
  parameter int KEY_WIDTH   = DEFAULT_KEY_WIDTH,
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int MEM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input logic          clk,
  input logic          reset,
  hash_lookup_if.slave bus
);

  localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int USED_WIDTH = PTR_WIDTH + 1;

  typedef struct packed {
    logic                   occupied;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } entry_t;

  typedef struct packed {
    logic                   hit;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] value;
  } result_t;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  delayed_valid;
  logic [KEY_WIDTH-1:0]  delayed_key;
  logic [KEY_WIDTH:0]    delay_out;
  logic [USED_WIDTH-1:0] used;
  logic [PTR_WIDTH:0]    wr_ptr;
  logic [PTR_WIDTH:0]    rd_ptr;
  entry_t                stored;
  result_t               result;
  result_t               head;
  result_t               fifo_mem [FIFO_DEPTH];

  // Credits cover in-flight reads plus queued results, so a push never meets a full FIFO.
  assign bus.req_ready   = !reset && (used < USED_WIDTH'(FIFO_DEPTH));
  assign accept          = bus.req_valid && bus.req_ready;
  assign bus.mem_rd_en   = accept;
  assign bus.mem_rd_addr = bus.req_addr;

  siso_register #(
    .DATA_WIDTH (KEY_WIDTH + 1),
    .DELAY      (MEM_LATENCY)
  ) u_key_delay (
    .clk      (clk),
    .reset    (reset),
    .write_en (1'b1),
    .data_in  ({accept, bus.req_key}),
    .data_out (delay_out)
  );

  assign delayed_valid = delay_out[KEY_WIDTH];
  assign delayed_key   = delay_out[KEY_WIDTH-1:0];
  assign stored        = entry_t'(bus.mem_rd_data);
  assign push          = delayed_valid;

  always_comb begin
    result       = '0;
    result.hit   = stored.occupied && (stored.key == delayed_key);
    result.key   = delayed_key;
    result.value = result.hit ? stored.value : '0;
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                      (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
  assign head       = fifo_mem[rd_ptr[PTR_WIDTH-1:0]];

  assign bus.res_valid = !reset && !fifo_empty;
  assign bus.res_hit   = bus.res_valid && head.hit;
  assign bus.res_key   = bus.res_valid ? head.key   : '0;
  assign bus.res_value = bus.res_valid ? head.value : '0;
  assign pop           = bus.res_valid && bus.res_ready;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_WIDTH-1:0]] <= result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_lookup_stage.sv
// Self-checking bench for hash_lookup_stage: directed scenarios with literal
// expectations plus a randomized run against a queue-based reference model.
module tb_hash_lookup_stage;
  import hash_table_pkg::*;

  localparam int KW = 10;
  localparam int VW = 16;
  localparam int AW = 8;
  localparam int ML = 2;
  localparam int FD = 4;
  localparam int EW = 1 + KW + VW;

  typedef struct {
    logic          hit;
    logic [KW-1:0] key;
    logic [VW-1:0] value;
    int            rdy;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   acc_count;
  exp_t q[$];
  exp_t item;
  bucket_entry_t e;
  bit   m_pop, m_acc, exp_ready, exp_valid;

  bucket_entry_t  mem [256];
  logic [EW-1:0]  mem_pipe [ML];

  always #5 clk = ~clk;

  hash_lookup_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .ADDR_WIDTH(AW)) bus ();

  hash_lookup_stage #(
    .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .ADDR_WIDTH(AW),
    .MEM_LATENCY(ML), .FIFO_DEPTH(FD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Bucket memory: returns data ML edges after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (bus.mem_rd_en) mem_pipe[0] <= mem[bus.mem_rd_addr];
    else               mem_pipe[0] <= EW'($urandom);
    for (int i = 1; i < ML; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign bus.mem_rd_data = mem_pipe[ML-1];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic [KW-1:0] key,
                               input logic [AW-1:0] addr, input logic rr);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.req_valid = v;
    bus.req_key   = key;
    bus.req_addr  = addr;
    bus.res_ready = rr;
  endtask

  // Reference model: every accepted request becomes one queued result, visible ML+1 cycles later.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      m_pop = (q.size() > 0) && (q[0].rdy <= cyc) && bus.res_ready;
      m_acc = bus.req_valid && (q.size() < FD);
      if (m_acc) begin
        e          = mem[bus.req_addr];
        item.hit   = e.occupied && (e.key == bus.req_key);
        item.key   = bus.req_key;
        item.value = item.hit ? e.value : '0;
        item.rdy   = cyc + ML + 1;
        q.push_back(item);
      end
      if (m_pop) void'(q.pop_front());
    end
    cyc++;
  end

  always @(negedge clk) begin
    exp_ready = !reset && (q.size() < FD);
    exp_valid = !reset && (q.size() > 0) && (q[0].rdy <= cyc);
    checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    checkOutput("mem_rd_en", 32'(bus.mem_rd_en), 32'(bus.req_valid && exp_ready));
    if (bus.mem_rd_en) checkOutput("mem_rd_addr", 32'(bus.mem_rd_addr), 32'(bus.req_addr));
    checkOutput("res_valid", 32'(bus.res_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("res_hit",   32'(bus.res_hit),   32'(q[0].hit));
      checkOutput("res_key",   32'(bus.res_key),   32'(q[0].key));
      checkOutput("res_value", 32'(bus.res_value), 32'(q[0].value));
    end else begin
      checkOutput("idle_res", {bus.res_hit, bus.res_value, 5'd0, bus.res_key}, 32'd0);
    end
    checkOutput("push_to_full", 32'(dut.push && dut.fifo_full), 32'd0);
  end

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      applyStimulus(0, 0, '0, '0, 1);
      n++;
    end
    checkOutput("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_key   = '0;
    bus.req_addr  = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h05] = '{occupied: 1'b1, key: 10'h155, value: 16'hBEEF};
    mem[8'h06] = '{occupied: 1'b1, key: 10'h154, value: 16'h1234};
    mem[8'h07] = '{occupied: 1'b0, key: 10'h155, value: 16'h5678};
    for (int i = 0; i < 8; i++)
      mem[8'h10 + i] = '{occupied: 1'b1, key: KW'(10'h100 + i), value: VW'(16'h1000 + i)};

    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, '0, '0, 1);
      @(negedge clk);
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
      checkOutput("rst_mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
      checkOutput("rst_res_fields", {bus.res_hit, bus.res_value, 5'd0, bus.res_key}, 32'd0);
    end
    applyStimulus(0, 0, '0, '0, 1);
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // Single hit: strobe in cycle 0, result in cycle 3.
    for (int k = 0; k < 4; k++) begin
      if (k == 0) applyStimulus(0, 1, 10'h155, 8'h05, 1);
      else        applyStimulus(0, 0, '0, '0, 1);
      @(negedge clk);
      if (k == 0) begin
        checkOutput("hit_rd_en", 32'(bus.mem_rd_en), 32'd1);
        checkOutput("hit_rd_addr", 32'(bus.mem_rd_addr), 32'h05);
      end
      if (k == 2) checkOutput("hit_early_valid", 32'(bus.res_valid), 32'd0);
      if (k == 3) begin
        checkOutput("hit_valid", 32'(bus.res_valid), 32'd1);
        checkOutput("hit_hit",   32'(bus.res_hit),   32'd1);
        checkOutput("hit_value", 32'(bus.res_value), 32'hBEEF);
        checkOutput("hit_key",   32'(bus.res_key),   32'h155);
      end
    end

    // Key mismatch, then unoccupied entry with matching key.
    for (int k = 0; k < 5; k++) begin
      if (k == 0)      applyStimulus(0, 1, 10'h155, 8'h06, 1);
      else if (k == 1) applyStimulus(0, 1, 10'h155, 8'h07, 1);
      else             applyStimulus(0, 0, '0, '0, 1);
      @(negedge clk);
      if (k >= 3) begin
        checkOutput("miss_valid", 32'(bus.res_valid), 32'd1);
        checkOutput("miss_hit",   32'(bus.res_hit),   32'd0);
        checkOutput("miss_value", 32'(bus.res_value), 32'd0);
      end
    end

    // Streaming: 8 back-to-back requests, results on cycles 3..10.
    for (int k = 0; k < 12; k++) begin
      if (k < 8) applyStimulus(0, 1, KW'(10'h100 + k), AW'(8'h10 + k), 1);
      else       applyStimulus(0, 0, '0, '0, 1);
      @(negedge clk);
      if (k < 8) checkOutput("stream_ready", 32'(bus.req_ready), 32'd1);
      if (k >= 3 && k <= 10) begin
        checkOutput("stream_valid", 32'(bus.res_valid), 32'd1);
        checkOutput("stream_key", 32'(bus.res_key), 32'h100 + 32'(k - 3));
        checkOutput("stream_value", 32'(bus.res_value), 32'h1000 + 32'(k - 3));
      end
      if (k == 11) checkOutput("stream_end_valid", 32'(bus.res_valid), 32'd0);
    end

    // Back-pressure: 6 offered, 4 accepted, ready returns after the first pop.
    acc_count = 0;
    for (int k = 0; k < 11; k++) begin
      applyStimulus(0, k < 6, KW'(10'h200 + k), AW'(8'h20 + k), k >= 6);
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) acc_count++;
      if (k == 4 || k == 5 || k == 6) checkOutput("bp_ready_low", 32'(bus.req_ready), 32'd0);
      if (k == 7) checkOutput("bp_ready_back", 32'(bus.req_ready), 32'd1);
      if (k >= 6 && k <= 9) checkOutput("bp_drain_valid", 32'(bus.res_valid), 32'd1);
      if (k == 10) checkOutput("bp_empty", 32'(bus.res_valid), 32'd0);
    end
    checkOutput("bp_accepted", 32'(acc_count), 32'd4);

    // Accept and pop together at used=4 (blocked) and used=3 (stays 3).
    for (int k = 0; k < 11; k++) begin
      applyStimulus(0, (k < 4) || (k >= 7 && k <= 9), KW'(10'h155), 8'h05, k == 7 || k == 8);
      @(negedge clk);
      if (k == 7) begin
        checkOutput("sim_full_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("sim_full_rd_en", 32'(bus.mem_rd_en), 32'd0);
      end
      if (k == 8 || k == 9) checkOutput("sim_used3_ready", 32'(bus.req_ready), 32'd1);
      if (k == 10) checkOutput("sim_used4_ready", 32'(bus.req_ready), 32'd0);
    end
    drain();

    // Reset with two requests in flight, then a fresh request.
    for (int k = 0; k < 14; k++) begin
      if (k < 2)       applyStimulus(0, 1, 10'h155, 8'h05, 1);
      else if (k == 2) applyStimulus(1, 0, '0, '0, 1);
      else if (k == 10) applyStimulus(0, 1, 10'h155, 8'h05, 1);
      else             applyStimulus(0, 0, '0, '0, 1);
      @(negedge clk);
      if (k == 3) checkOutput("rstmid_ready", 32'(bus.req_ready), 32'd1);
      if (k >= 2 && k <= 9) checkOutput("rstmid_no_valid", 32'(bus.res_valid), 32'd0);
      if (k == 13) begin
        checkOutput("rstmid_new_valid", 32'(bus.res_valid), 32'd1);
        checkOutput("rstmid_new_value", 32'(bus.res_value), 32'hBEEF);
      end
    end

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 256; i++) mem[i] = bucket_entry_t'($urandom);
    for (int n = 0; n < 800; n++) begin
      logic [AW-1:0] a;
      logic [KW-1:0] kk;
      a  = AW'($urandom_range(0, 15));
      kk = ($urandom_range(0, 1) == 1) ? mem[a].key : KW'($urandom);
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, kk, a,
                    $urandom_range(0, 3) != 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
